// File: rtl/drac_pkg.sv
// Shared types for the wb-stage commit path: physical register tags, exception
// causes, graduation list entry layout and the commit unit state encoding.
package drac_pkg;

   localparam int PHREG_W  = 6;
   localparam int PHVREG_W = 6;
   localparam int GL_IDX_W = 5;
   localparam int ADDR_W   = 40;

   typedef logic [PHREG_W-1:0]  phreg_t;
   typedef logic [PHVREG_W-1:0] phvreg_t;
   typedef logic [GL_IDX_W-1:0] gl_index_t;
   typedef logic [ADDR_W-1:0]   addr_t;

   typedef enum logic [3:0] {
      INSTR_ADDR_MISALIGNED  = 4'd0,
      INSTR_ACCESS_FAULT     = 4'd1,
      ILLEGAL_INSTR          = 4'd2,
      BREAKPOINT             = 4'd3,
      LD_ADDR_MISALIGNED     = 4'd4,
      LD_ACCESS_FAULT        = 4'd5,
      ST_AMO_ADDR_MISALIGNED = 4'd6,
      ST_AMO_ACCESS_FAULT    = 4'd7,
      USER_ECALL             = 4'd8,
      SUPERVISOR_ECALL       = 4'd9,
      MACHINE_ECALL          = 4'd11,
      INSTR_PAGE_FAULT       = 4'd12,
      LD_PAGE_FAULT          = 4'd13,
      ST_AMO_PAGE_FAULT      = 4'd15
   } exception_cause_t;

   typedef enum logic [2:0] {
      ALU    = 3'd0,
      MUL    = 3'd1,
      BRANCH = 3'd2,
      LOAD   = 3'd3,
      STORE  = 3'd4,
      AMO    = 3'd5,
      SYSTEM = 3'd6,
      VECTOR = 3'd7
   } instr_type_t;

   typedef struct packed {
      logic             valid;
      exception_cause_t cause;
   } exception_t;

   typedef struct packed {
      logic        valid;
      addr_t       pc;
      instr_type_t instr_type;
      logic        stall_csr_fence;
      phreg_t      old_prd;
      phvreg_t     old_pvd;
      exception_t  exception;
   } gl_instruction_t;

   typedef enum logic [1:0] {
      RUN        = 2'd0,
      WAIT_STORE = 2'd1,
      WAIT_CSR   = 2'd2,
      FLUSH      = 2'd3
   } commit_state_t;

   // A CSR unit fault carries no cause of its own, so it is reported as illegal.
   localparam exception_cause_t CSR_FAULT_CAUSE = ILLEGAL_INSTR;

   // Stores and AMOs may only touch memory once they are the oldest instruction.
   function automatic logic is_store_or_amo(input instr_type_t t);
      return (t == STORE) || (t == AMO);
   endfunction

endpackage

// File: rtl/commit_unit.sv
// Commit unit: drains the graduation list head in order, one retire per cycle.
// Stores/AMOs wait for the store buffer, CSR/fence ops wait for the CSR unit and
// always flush afterwards, faulting instructions trap and flush.
// Optional feature: define COMMIT_PERF_CNT_EN to add the instret_o counter port.
module commit_unit
   import drac_pkg::*;
#(
   parameter int COMMIT_CNT_W = 32
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    gl_empty_i,
   input  gl_instruction_t         gl_instr_i,
   input  gl_index_t               gl_entry_i,
   output logic                    read_head_o,
   output logic                    flush_commit_o,
   output logic                    store_commit_o,
   input  logic                    store_ack_i,
   output logic                    csr_req_o,
   input  logic                    csr_done_i,
   input  logic                    csr_xcpt_i,
   output logic                    free_prd_valid_o,
   output phreg_t                  free_prd_o,
   output logic                    free_pvd_valid_o,
   output phvreg_t                 free_pvd_o,
   output logic                    trap_valid_o,
   output exception_cause_t        trap_cause_o,
   output addr_t                   trap_pc_o,
   output logic                    commit_valid_o,
`ifdef COMMIT_PERF_CNT_EN
   output logic [COMMIT_CNT_W-1:0] instret_o,
`endif
   output gl_index_t               commit_entry_o
);

   commit_state_t state_q, state_d;

   // The head popped on entry to a wait state is gone from the GL, so it is kept here.
   addr_t     held_pc_q;
   phreg_t    held_prd_q;
   phvreg_t   held_pvd_q;
   gl_index_t held_entry_q;

   logic      latch_en;
   logic      needs_wait;
   logic      retire;
   phreg_t    ret_prd;
   phvreg_t   ret_pvd;
   gl_index_t ret_entry;

   assign needs_wait = gl_instr_i.exception.valid | gl_instr_i.stall_csr_fence |
                       is_store_or_amo(gl_instr_i.instr_type);

   // State register and the copy of the instruction that is waiting on another unit.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q      <= RUN;
         held_pc_q    <= '0;
         held_prd_q   <= '0;
         held_pvd_q   <= '0;
         held_entry_q <= '0;
      end else begin
         state_q <= state_d;
         if (latch_en) begin
            held_pc_q    <= gl_instr_i.pc;
            held_prd_q   <= gl_instr_i.old_prd;
            held_pvd_q   <= gl_instr_i.old_pvd;
            held_entry_q <= gl_entry_i;
         end
      end
   end

   // Next state plus all handshake, trap, retire and free outputs; silent while in reset.
   always_comb begin
      state_d          = state_q;
      latch_en         = 1'b0;
      retire           = 1'b0;
      ret_prd          = '0;
      ret_pvd          = '0;
      ret_entry        = '0;
      read_head_o      = 1'b0;
      flush_commit_o   = 1'b0;
      store_commit_o   = 1'b0;
      csr_req_o        = 1'b0;
      trap_valid_o     = 1'b0;
      trap_cause_o     = INSTR_ADDR_MISALIGNED;
      trap_pc_o        = '0;
      commit_valid_o   = 1'b0;
      commit_entry_o   = '0;
      free_prd_valid_o = 1'b0;
      free_prd_o       = '0;
      free_pvd_valid_o = 1'b0;
      free_pvd_o       = '0;

      unique case (state_q)
         RUN: begin
            if (gl_instr_i.valid) begin
               if (gl_instr_i.exception.valid) begin
                  trap_valid_o   = 1'b1;
                  trap_cause_o   = gl_instr_i.exception.cause;
                  trap_pc_o      = gl_instr_i.pc;
                  flush_commit_o = 1'b1;
                  state_d        = FLUSH;
               end else if (gl_instr_i.stall_csr_fence) begin
                  csr_req_o = 1'b1;
                  latch_en  = 1'b1;
                  state_d   = WAIT_CSR;
               end else if (is_store_or_amo(gl_instr_i.instr_type)) begin
                  store_commit_o = 1'b1;
                  latch_en       = 1'b1;
                  state_d        = WAIT_STORE;
               end else begin
                  retire    = 1'b1;
                  ret_prd   = gl_instr_i.old_prd;
                  ret_pvd   = gl_instr_i.old_pvd;
                  ret_entry = gl_entry_i;
               end
            end
         end
         WAIT_STORE: begin
            if (store_ack_i) begin
               retire    = 1'b1;
               ret_prd   = held_prd_q;
               ret_pvd   = held_pvd_q;
               ret_entry = held_entry_q;
               state_d   = RUN;
            end
         end
         WAIT_CSR: begin
            if (csr_done_i) begin
               flush_commit_o = 1'b1;
               state_d        = FLUSH;
               if (csr_xcpt_i) begin
                  trap_valid_o = 1'b1;
                  trap_cause_o = CSR_FAULT_CAUSE;
                  trap_pc_o    = held_pc_q;
               end else begin
                  retire    = 1'b1;
                  ret_prd   = held_prd_q;
                  ret_pvd   = held_pvd_q;
                  ret_entry = held_entry_q;
               end
            end
         end
         FLUSH: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      read_head_o = (state_q == RUN) & ~gl_empty_i &
                    ~(gl_instr_i.valid & needs_wait) & ~flush_commit_o;

      if (retire) begin
         commit_valid_o   = 1'b1;
         commit_entry_o   = ret_entry;
         free_prd_valid_o = (ret_prd != '0);
         free_prd_o       = ret_prd;
         free_pvd_valid_o = (ret_pvd != '0);
         free_pvd_o       = ret_pvd;
      end

      if (!rstn_i) begin
         read_head_o      = 1'b0;
         flush_commit_o   = 1'b0;
         store_commit_o   = 1'b0;
         csr_req_o        = 1'b0;
         trap_valid_o     = 1'b0;
         trap_cause_o     = INSTR_ADDR_MISALIGNED;
         trap_pc_o        = '0;
         commit_valid_o   = 1'b0;
         commit_entry_o   = '0;
         free_prd_valid_o = 1'b0;
         free_prd_o       = '0;
         free_pvd_valid_o = 1'b0;
         free_pvd_o       = '0;
      end
   end

`ifdef COMMIT_PERF_CNT_EN
   logic [COMMIT_CNT_W-1:0] instret_q;

   // Retired-instruction counter; free running, wraps, and survives pipeline flushes.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         instret_q <= '0;
      end else if (commit_valid_o) begin
         instret_q <= instret_q + COMMIT_CNT_W'(1);
      end
   end

   assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Testbench for commit_unit: a queue-based graduation list, a transaction model of
// what must retire, trap or wait, directed scenarios and a randomized run.
// Define COMMIT_PERF_CNT_EN to also exercise the instret_o counter.
module tb_commit_unit;
   import drac_pkg::*;

   localparam int TB_CNT_W = 4;

   typedef struct {
      gl_instruction_t ins;
      gl_index_t       entry;
   } gl_item_t;

   logic             clk_i = 1'b0;
   logic             rstn_i = 1'b0;
   logic             gl_empty_i = 1'b1;
   gl_instruction_t  gl_instr_i = '0;
   gl_index_t        gl_entry_i = '0;
   logic             read_head_o, flush_commit_o, store_commit_o, csr_req_o;
   logic             store_ack_i = 1'b0, csr_done_i = 1'b0, csr_xcpt_i = 1'b0;
   logic             free_prd_valid_o, free_pvd_valid_o, trap_valid_o, commit_valid_o;
   phreg_t           free_prd_o;
   phvreg_t          free_pvd_o;
   exception_cause_t trap_cause_o;
   addr_t            trap_pc_o;
   gl_index_t        commit_entry_o;
`ifdef COMMIT_PERF_CNT_EN
   logic [TB_CNT_W-1:0] instret_o;
`endif

   gl_item_t    glq[$];
   gl_item_t    waitq[$];
   gl_item_t    pres;
   logic        pres_v = 1'b0;
   logic        quiet = 1'b0;
   int unsigned retire_cnt = 0;
   gl_index_t   next_entry = '0;
   int          assert_cnt = 0;
   int          fail_cnt = 0;

   always #5 clk_i = ~clk_i;

   commit_unit #(.COMMIT_CNT_W(TB_CNT_W)) dut (
      .clk_i            (clk_i),
      .rstn_i           (rstn_i),
      .gl_empty_i       (gl_empty_i),
      .gl_instr_i       (gl_instr_i),
      .gl_entry_i       (gl_entry_i),
      .read_head_o      (read_head_o),
      .flush_commit_o   (flush_commit_o),
      .store_commit_o   (store_commit_o),
      .store_ack_i      (store_ack_i),
      .csr_req_o        (csr_req_o),
      .csr_done_i       (csr_done_i),
      .csr_xcpt_i       (csr_xcpt_i),
      .free_prd_valid_o (free_prd_valid_o),
      .free_prd_o       (free_prd_o),
      .free_pvd_valid_o (free_pvd_valid_o),
      .free_pvd_o       (free_pvd_o),
      .trap_valid_o     (trap_valid_o),
      .trap_cause_o     (trap_cause_o),
      .trap_pc_o        (trap_pc_o),
      .commit_valid_o   (commit_valid_o),
`ifdef COMMIT_PERF_CNT_EN
      .instret_o        (instret_o),
`endif
      .commit_entry_o   (commit_entry_o)
   );

   task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
      assert_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_instr(input instr_type_t t, input logic stall, input logic exc,
                             input exception_cause_t cause, input addr_t pc,
                             input phreg_t prd, input phvreg_t pvd);
      gl_item_t it;
      it.ins                 = '0;
      it.ins.valid           = 1'b1;
      it.ins.pc              = pc;
      it.ins.instr_type      = t;
      it.ins.stall_csr_fence = stall;
      it.ins.old_prd         = prd;
      it.ins.old_pvd         = pvd;
      it.ins.exception.valid = exc;
      it.ins.exception.cause = cause;
      it.entry               = next_entry;
      next_entry             = next_entry + 1'b1;
      glq.push_back(it);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_read"},   read_head_o, 0);
      check_val({tag, "_flush"},  flush_commit_o, 0);
      check_val({tag, "_store"},  store_commit_o, 0);
      check_val({tag, "_csr"},    csr_req_o, 0);
      check_val({tag, "_fprdv"},  free_prd_valid_o, 0);
      check_val({tag, "_fprd"},   free_prd_o, 0);
      check_val({tag, "_fpvdv"},  free_pvd_valid_o, 0);
      check_val({tag, "_fpvd"},   free_pvd_o, 0);
      check_val({tag, "_trap"},   trap_valid_o, 0);
      check_val({tag, "_cause"},  trap_cause_o, 0);
      check_val({tag, "_pc"},     trap_pc_o, 0);
      check_val({tag, "_commit"}, commit_valid_o, 0);
      check_val({tag, "_entry"},  commit_entry_o, 0);
`ifdef COMMIT_PERF_CNT_EN
      check_val({tag, "_instret"}, instret_o, 0);
`endif
   endtask

   // Asserts reset asynchronously, checks the outputs drop at once, clears the model.
   task automatic applyReset();
      rstn_i = 1'b0;
      #1;
      check_all_zero("rst");
      store_ack_i = 1'b0;
      csr_done_i  = 1'b0;
      csr_xcpt_i  = 1'b0;
      gl_empty_i  = 1'b1;
      gl_instr_i  = '0;
      gl_entry_i  = '0;
      glq.delete();
      waitq.delete();
      pres_v     = 1'b0;
      quiet      = 1'b0;
      retire_cnt = 0;
      next_entry = '0;
      repeat (2) @(posedge clk_i);
      #2 rstn_i = 1'b1;
   endtask

   // Compares every output with the model for this cycle, then advances the model.
   task automatic checkOutput();
      logic e_read, e_flush, e_store, e_csr, e_trap, e_commit;
      exception_cause_t e_cause;
      addr_t e_pc;
      gl_item_t r, w;
      logic needs;
      e_read = 0; e_flush = 0; e_store = 0; e_csr = 0; e_trap = 0; e_commit = 0;
      e_cause = INSTR_ADDR_MISALIGNED; e_pc = '0; r.ins = '0; r.entry = '0;
      if (quiet) begin
         quiet = 1'b0;
      end else if (waitq.size() != 0) begin
         w = waitq[0];
         if (!w.ins.stall_csr_fence) begin
            if (store_ack_i) begin
               e_commit = 1; r = w;
               void'(waitq.pop_front());
            end
         end else if (csr_done_i) begin
            e_flush = 1; quiet = 1'b1;
            if (csr_xcpt_i) begin
               e_trap = 1; e_cause = ILLEGAL_INSTR; e_pc = w.ins.pc;
            end else begin
               e_commit = 1; r = w;
            end
            void'(waitq.pop_front());
         end
      end else begin
         needs = 0;
         if (pres_v) begin
            needs = pres.ins.exception.valid | pres.ins.stall_csr_fence |
                    (pres.ins.instr_type == STORE) | (pres.ins.instr_type == AMO);
            if (pres.ins.exception.valid) begin
               e_trap = 1; e_flush = 1; quiet = 1'b1;
               e_cause = pres.ins.exception.cause; e_pc = pres.ins.pc;
            end else if (pres.ins.stall_csr_fence) begin
               e_csr = 1; waitq.push_back(pres);
            end else if (needs) begin
               e_store = 1; waitq.push_back(pres);
            end else begin
               e_commit = 1; r = pres;
            end
         end
         e_read = !gl_empty_i && !needs;
      end
      if (e_commit) retire_cnt++;

      check_val("read_head", read_head_o, e_read);
      check_val("flush", flush_commit_o, e_flush);
      check_val("store_commit", store_commit_o, e_store);
      check_val("csr_req", csr_req_o, e_csr);
      check_val("trap_valid", trap_valid_o, e_trap);
      if (e_trap) begin
         check_val("trap_cause", trap_cause_o, e_cause);
         check_val("trap_pc", trap_pc_o, e_pc);
      end
      check_val("commit_valid", commit_valid_o, e_commit);
      check_val("free_prd_valid", free_prd_valid_o, e_commit && (r.ins.old_prd != 0));
      check_val("free_pvd_valid", free_pvd_valid_o, e_commit && (r.ins.old_pvd != 0));
      if (e_commit) begin
         check_val("commit_entry", commit_entry_o, r.entry);
         if (r.ins.old_prd != 0) check_val("free_prd", free_prd_o, r.ins.old_prd);
         if (r.ins.old_pvd != 0) check_val("free_pvd", free_pvd_o, r.ins.old_pvd);
      end
`ifdef COMMIT_PERF_CNT_EN
      check_val("instret", instret_o, retire_cnt - (e_commit ? 1 : 0));
`endif

      if (e_flush) glq.delete();
      pres_v = e_read;
      if (e_read) pres = glq.pop_front();
   endtask

   // One clock cycle: drive the GL head and handshakes after the edge, check at negedge.
   task automatic applyStimulus(input logic ack, input logic done, input logic xcpt);
      @(posedge clk_i);
      #1;
      store_ack_i = ack;
      csr_done_i  = done;
      csr_xcpt_i  = xcpt;
      gl_empty_i  = (glq.size() == 0);
      gl_instr_i  = pres_v ? pres.ins : '0;
      gl_entry_i  = pres_v ? pres.entry : '0;
      @(negedge clk_i);
      checkOutput();
   endtask

   initial begin
      instr_type_t t;
      applyReset();

      // Three ALU instructions retire on consecutive cycles
      push_instr(ALU, 0, 0, INSTR_ADDR_MISALIGNED, 40'h100, 6'd5, 6'd0);
      push_instr(MUL, 0, 0, INSTR_ADDR_MISALIGNED, 40'h104, 6'd0, 6'd2);
      push_instr(ALU, 0, 0, INSTR_ADDR_MISALIGNED, 40'h108, 6'd7, 6'd0);
      applyStimulus(0, 0, 0);
      check_val("alu_c0_read", read_head_o, 1);
      check_val("alu_c0_commit", commit_valid_o, 0);
      applyStimulus(0, 0, 0);
      check_val("alu_c1_commit", commit_valid_o, 1);
      check_val("alu_c1_entry", commit_entry_o, 0);
      check_val("alu_c1_fprd", free_prd_o, 5);
      check_val("alu_c1_fpvdv", free_pvd_valid_o, 0);
      applyStimulus(0, 0, 0);
      check_val("alu_c2_entry", commit_entry_o, 1);
      check_val("alu_c2_fprdv", free_prd_valid_o, 0);
      check_val("alu_c2_fpvd", free_pvd_o, 2);
      applyStimulus(0, 0, 0);
      check_val("alu_c3_commit", commit_valid_o, 1);
      check_val("alu_c3_entry", commit_entry_o, 2);
      check_val("alu_c3_read", read_head_o, 0);

      // Store waits four cycles for the store buffer ack
      applyReset();
      push_instr(STORE, 0, 0, INSTR_ADDR_MISALIGNED, 40'h200, 6'd9, 6'd0);
      push_instr(ALU, 0, 0, INSTR_ADDR_MISALIGNED, 40'h204, 6'd1, 6'd0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      check_val("st_pulse", store_commit_o, 1);
      check_val("st_pulse_read", read_head_o, 0);
      repeat (3) begin
         applyStimulus(0, 0, 0);
         check_val("st_wait_read", read_head_o, 0);
         check_val("st_wait_pulse", store_commit_o, 0);
      end
      applyStimulus(1, 0, 0);
      check_val("st_ack_commit", commit_valid_o, 1);
      check_val("st_ack_fprd", free_prd_o, 9);
      applyStimulus(0, 0, 0);
      check_val("st_after_read", read_head_o, 1);
      applyStimulus(0, 0, 0);
      check_val("st_next_entry", commit_entry_o, 1);

      // CSR op completes after two cycles, retires and flushes
      applyReset();
      push_instr(SYSTEM, 1, 0, INSTR_ADDR_MISALIGNED, 40'h300, 6'd3, 6'd0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      check_val("csr_req", csr_req_o, 1);
      applyStimulus(0, 0, 0);
      check_val("csr_req_once", csr_req_o, 0);
      applyStimulus(0, 1, 0);
      check_val("csr_commit", commit_valid_o, 1);
      check_val("csr_flush", flush_commit_o, 1);
      push_instr(ALU, 0, 0, INSTR_ADDR_MISALIGNED, 40'h400, 6'd0, 6'd0);
      applyStimulus(0, 0, 0);
      check_val("csr_flushcyc_read", read_head_o, 0);
      check_val("csr_flushcyc_flush", flush_commit_o, 0);
      applyStimulus(0, 0, 0);
      check_val("csr_run_read", read_head_o, 1);

      // Exception at the head traps and flushes with no retire
      applyReset();
      push_instr(LOAD, 0, 1, ILLEGAL_INSTR, 40'h80000010, 6'd4, 6'd0);
      push_instr(ALU, 0, 0, INSTR_ADDR_MISALIGNED, 40'h80000014, 6'd2, 6'd0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      check_val("xcpt_trap", trap_valid_o, 1);
      check_val("xcpt_cause", trap_cause_o, ILLEGAL_INSTR);
      check_val("xcpt_pc", trap_pc_o, 40'h80000010);
      check_val("xcpt_flush", flush_commit_o, 1);
      check_val("xcpt_commit", commit_valid_o, 0);
      check_val("xcpt_free", free_prd_valid_o, 0);

      // Reset while waiting for a store ack drops the request
      applyReset();
      push_instr(AMO, 0, 0, INSTR_ADDR_MISALIGNED, 40'h500, 6'd6, 6'd0);
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      check_val("rw_pulse", store_commit_o, 1);
      applyStimulus(0, 0, 0);
      store_ack_i = 1'b1;
      #1;
      check_val("rw_pre_reset_commit", commit_valid_o, 1);
      applyReset();
      applyStimulus(1, 0, 0);
      check_val("rw_late_ack_commit", commit_valid_o, 0);
      applyStimulus(1, 0, 0);
      check_val("rw_late_ack_commit2", commit_valid_o, 0);

`ifdef COMMIT_PERF_CNT_EN
      // Seventeen retires wrap a 4-bit counter to one
      applyReset();
      repeat (17) push_instr(ALU, 0, 0, INSTR_ADDR_MISALIGNED, 40'h600, 6'd1, 6'd0);
      repeat (19) applyStimulus(0, 0, 0);
      check_val("instret_wrap", instret_o, 1);
`endif

      // Randomized traffic
      applyReset();
      for (int i = 0; i < 3000; i++) begin
         if (glq.size() < 6 && $urandom_range(0, 1) == 1) begin
            t = instr_type_t'($urandom_range(0, 7));
            push_instr(t, (t == SYSTEM) && ($urandom_range(0, 1) == 1),
                       $urandom_range(0, 15) == 0,
                       exception_cause_t'($urandom_range(0, 9)),
                       addr_t'({$urandom, $urandom}),
                       ($urandom_range(0, 3) == 0) ? phreg_t'(0) : phreg_t'($urandom),
                       ($urandom_range(0, 2) != 0) ? phvreg_t'(0) : phvreg_t'($urandom));
         end
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                       $urandom_range(0, 2) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
